// File: rtl/broadcast_filter_sched.sv
// Probe-filter lookup scheduler: round-robin grant across trackers,
// one-entry output stage, in-flight tracker/address blocking, response demux.
module broadcast_filter_sched #(
  parameter int N_TRACKERS = 4,
  parameter int MSHR_W     = 2,
  parameter int ADDR_W     = 26
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_TRACKERS-1:0]        req_valid,
  output logic [N_TRACKERS-1:0]        req_ready,
  input  logic [N_TRACKERS*ADDR_W-1:0] req_address,
  input  logic [N_TRACKERS-1:0]        req_allocOH,
  input  logic [N_TRACKERS-1:0]        req_needT,
  output logic                         filt_req_valid,
  input  logic                         filt_req_ready,
  output logic [MSHR_W-1:0]            filt_req_mshr,
  output logic [ADDR_W-1:0]            filt_req_address,
  output logic                         filt_req_allocOH,
  output logic                         filt_req_needT,
  input  logic                         filt_resp_valid,
  output logic                         filt_resp_ready,
  input  logic [MSHR_W-1:0]            filt_resp_mshr,
  input  logic                         filt_resp_allocOH,
  input  logic                         filt_resp_needT,
  output logic [N_TRACKERS-1:0]        resp_valid,
  input  logic [N_TRACKERS-1:0]        resp_ready,
  output logic                         resp_allocOH,
  output logic                         resp_needT,
  output logic                         err_orphan
);

  localparam int N = N_TRACKERS;

  logic [N-1:0]      pending_q, pending_d;
  logic [ADDR_W-1:0] pend_addr_q [N];
  logic [MSHR_W-1:0] last_q;
  logic              ovalid_q, ovalid_d;
  logic [MSHR_W-1:0] omshr_q;
  logic [ADDR_W-1:0] oaddr_q;
  logic              oalloc_q;
  logic              oneedt_q;
  logic              orphan_q, orphan_d;

  logic [ADDR_W-1:0] req_addr_a [N];
  logic [N-1:0]      conflict;
  logic [N-1:0]      eligible;
  logic              slot_free;
  logic              gnt_any;
  logic              do_grant;
  logic [MSHR_W-1:0] gnt_idx;
  logic [MSHR_W-1:0] scan_idx;
  logic              resp_fire;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr_a[i] = req_address[i*ADDR_W +: ADDR_W];
    end
  end

  // Conflicts look only at registered in-flight addresses.
  always_comb begin
    conflict = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (pending_q[j] && (pend_addr_q[j] == req_addr_a[i])) begin
          conflict[i] = 1'b1;
        end
      end
    end
  end

  assign eligible  = req_valid & ~pending_q & ~conflict;
  assign slot_free = ~ovalid_q | filt_req_ready;

  // Scan last+1 .. last+N; the tag width wraps the index modulo N.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 1; k <= N; k++) begin
      scan_idx = last_q + MSHR_W'(k);
      if (!gnt_any && eligible[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  assign do_grant = gnt_any & slot_free;

  always_comb begin
    req_ready = '0;
    if (do_grant) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (filt_resp_valid) resp_valid[filt_resp_mshr] = 1'b1;
  end

  assign filt_resp_ready = filt_resp_valid & resp_ready[filt_resp_mshr];
  assign resp_fire       = filt_resp_ready;
  assign resp_allocOH    = filt_resp_allocOH;
  assign resp_needT      = filt_resp_needT;

  // A fresh grant wins over a same-index clear.
  always_comb begin
    pending_d = pending_q;
    if (resp_fire) pending_d[filt_resp_mshr] = 1'b0;
    if (do_grant)  pending_d[gnt_idx]        = 1'b1;
  end

  assign orphan_d = orphan_q | (resp_fire & ~pending_q[filt_resp_mshr]);

  always_comb begin
    ovalid_d = ovalid_q;
    if (do_grant)            ovalid_d = 1'b1;
    else if (filt_req_ready) ovalid_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      last_q    <= MSHR_W'(N - 1);
      ovalid_q  <= 1'b0;
      omshr_q   <= '0;
      oaddr_q   <= '0;
      oalloc_q  <= 1'b0;
      oneedt_q  <= 1'b0;
      orphan_q  <= 1'b0;
      for (int i = 0; i < N; i++) pend_addr_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      ovalid_q  <= ovalid_d;
      orphan_q  <= orphan_d;
      if (do_grant) begin
        last_q               <= gnt_idx;
        omshr_q              <= gnt_idx;
        oaddr_q              <= req_addr_a[gnt_idx];
        oalloc_q             <= req_allocOH[gnt_idx];
        oneedt_q             <= req_needT[gnt_idx];
        pend_addr_q[gnt_idx] <= req_addr_a[gnt_idx];
      end
    end
  end

  assign filt_req_valid   = ovalid_q;
  assign filt_req_mshr    = omshr_q;
  assign filt_req_address = oaddr_q;
  assign filt_req_allocOH = oalloc_q;
  assign filt_req_needT   = oneedt_q;
  assign err_orphan       = orphan_q;

endmodule

// File: tb/tb_broadcast_filter_sched.sv
// Directed bench for broadcast_filter_sched with a scoreboard on the
// filter request channel.
module tb_broadcast_filter_sched;

  localparam int N  = 4;
  localparam int MW = 2;
  localparam int AW = 26;

  typedef logic [MW+AW+1:0] exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*AW-1:0] req_address = '0;
  logic [N-1:0]  req_allocOH = '0;
  logic [N-1:0]  req_needT = '0;
  logic          filt_req_valid;
  logic          filt_req_ready = 1'b0;
  logic [MW-1:0] filt_req_mshr;
  logic [AW-1:0] filt_req_address;
  logic          filt_req_allocOH;
  logic          filt_req_needT;
  logic          filt_resp_valid = 1'b0;
  logic          filt_resp_ready;
  logic [MW-1:0] filt_resp_mshr = '0;
  logic          filt_resp_allocOH = 1'b0;
  logic          filt_resp_needT = 1'b0;
  logic [N-1:0]  resp_valid;
  logic [N-1:0]  resp_ready = '0;
  logic          resp_allocOH;
  logic          resp_needT;
  logic          err_orphan;

  exp_t          sb[$];
  logic [AW-1:0] addr_m [N];
  int            passes = 0;
  int            total  = 0;

  broadcast_filter_sched #(
    .N_TRACKERS(N), .MSHR_W(MW), .ADDR_W(AW)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_allocOH(req_allocOH),
    .req_needT(req_needT),
    .filt_req_valid(filt_req_valid), .filt_req_ready(filt_req_ready),
    .filt_req_mshr(filt_req_mshr), .filt_req_address(filt_req_address),
    .filt_req_allocOH(filt_req_allocOH), .filt_req_needT(filt_req_needT),
    .filt_resp_valid(filt_resp_valid), .filt_resp_ready(filt_resp_ready),
    .filt_resp_mshr(filt_resp_mshr),
    .filt_resp_allocOH(filt_resp_allocOH),
    .filt_resp_needT(filt_resp_needT),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_allocOH(resp_allocOH), .resp_needT(resp_needT),
    .err_orphan(err_orphan)
  );

  always #5 clock = ~clock;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic pos();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(int i, logic [AW-1:0] a, logic al, logic nt);
    req_valid[i] = 1'b1;
    req_address[i*AW +: AW] = a;
    addr_m[i] = a;
    req_allocOH[i] = al;
    req_needT[i] = nt;
  endtask

  task automatic clr_req(int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic expect_grant(string tag, int g);
    logic [N-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    check(tag, req_ready, oh);
    sb.push_back({MW'(g), addr_m[g], req_allocOH[g], req_needT[g]});
  endtask

  task automatic resp_drive(int k, logic [N-1:0] rr);
    filt_resp_valid   = 1'b1;
    filt_resp_mshr    = MW'(k);
    filt_resp_needT   = k[0];
    filt_resp_allocOH = k[1];
    resp_ready        = rr;
  endtask

  task automatic resp_idle();
    filt_resp_valid = 1'b0;
    resp_ready      = '0;
  endtask

  task automatic respond(int k, logic [N-1:0] exp_rr);
    logic [N-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    resp_drive(k, '1);
    neg();
    check($sformatf("resp_valid_%0d", k), resp_valid, oh);
    check($sformatf("resp_ready_%0d", k), filt_resp_ready, 1);
    check($sformatf("resp_needT_%0d", k), resp_needT, k[0]);
    check($sformatf("resp_rr_%0d", k), req_ready, exp_rr);
    pos();
    resp_idle();
  endtask

  always @(negedge clock) begin
    if (!reset && filt_req_valid && filt_req_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_req", 64'(sb.size()), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_filt_req",
              {filt_req_mshr, filt_req_address,
               filt_req_allocOH, filt_req_needT}, e);
      end
    end
  end

  initial begin
    pos();
    reset = 1'b0;
    neg();
    check("rst_frv", filt_req_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_ready", filt_resp_ready, 0);
    check("rst_err", err_orphan, 0);
    check("rst_mshr", filt_req_mshr, 0);
    check("rst_addr", filt_req_address, 0);
    pos();

    // single request, 1-cycle latency, pending blocks its own tracker
    filt_req_ready = 1'b1;
    set_req(2, 26'h12345, 1'b0, 1'b1);
    neg();
    expect_grant("t1_grant", 2);
    pos();
    neg();
    check("t1_frv", filt_req_valid, 1);
    check("t1_mshr", filt_req_mshr, 2);
    check("t1_addr", filt_req_address, 26'h12345);
    check("t1_needT", filt_req_needT, 1);
    check("t1_pend_block", req_ready, 0);
    pos();
    clr_req(2);
    respond(2, 4'b0000);

    // round robin over four distinct addresses, full throughput
    reset = 1'b1;
    sb.delete();
    neg();
    pos();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 26'h100 + AW'(i), i[0], i[1]);
    for (int g = 0; g < N; g++) begin
      neg();
      expect_grant($sformatf("t2_grant%0d", g), g);
      pos();
      clr_req(g);
    end
    respond(2, 4'b0000);
    respond(0, 4'b0000);
    respond(3, 4'b0000);
    respond(1, 4'b0000);
    for (int i = 0; i < N; i++) set_req(i, 26'h200 + AW'(i), i[1], i[0]);
    for (int g = 0; g < N; g++) begin
      neg();
      expect_grant($sformatf("t2_regrant%0d", g), g);
      pos();
      clr_req(g);
    end
    for (int k = 0; k < N; k++) respond(k, 4'b0000);
    check("t2_err", err_orphan, 0);

    // same address from trackers 1 and 3
    set_req(1, 26'h0ABC, 1'b1, 1'b0);
    set_req(3, 26'h0ABC, 1'b0, 1'b0);
    neg();
    expect_grant("t3_g1", 1);
    pos();
    clr_req(1);
    repeat (2) begin
      neg();
      check("t3_blocked", req_ready, 0);
      pos();
    end
    respond(1, 4'b0000);
    neg();
    expect_grant("t3_g3", 3);
    pos();
    clr_req(3);
    respond(3, 4'b0000);

    // output stall then same-cycle reload
    filt_req_ready = 1'b0;
    set_req(0, 26'h3000, 1'b0, 1'b1);
    neg();
    expect_grant("t4_g0", 0);
    pos();
    clr_req(0);
    set_req(1, 26'h3001, 1'b1, 1'b0);
    repeat (5) begin
      neg();
      check("t4_hold_v", filt_req_valid, 1);
      check("t4_hold_m", filt_req_mshr, 0);
      check("t4_hold_a", filt_req_address, 26'h3000);
      check("t4_hold_rr", req_ready, 0);
      pos();
    end
    filt_req_ready = 1'b1;
    neg();
    expect_grant("t4_reload", 1);
    pos();
    clr_req(1);
    neg();
    check("t4_m1", filt_req_mshr, 1);
    check("t4_a1", filt_req_address, 26'h3001);
    pos();
    respond(0, 4'b0000);

    // response back-pressure on tracker 1, then orphan
    resp_drive(1, 4'b1101);
    repeat (3) begin
      neg();
      check("t5_rv_held", resp_valid, 4'b0010);
      check("t5_frr_low", filt_resp_ready, 0);
      pos();
    end
    resp_ready = '1;
    neg();
    check("t5_frr_high", filt_resp_ready, 1);
    pos();
    resp_idle();
    set_req(1, 26'h3001, 1'b0, 1'b0);
    neg();
    expect_grant("t5_p1_clear", 1);
    pos();
    clr_req(1);
    respond(1, 4'b0000);
    resp_drive(3, '1);
    neg();
    check("t5_err_pre", err_orphan, 0);
    check("t5_orphan_pass", resp_valid, 4'b1000);
    pos();
    resp_idle();
    repeat (2) begin
      neg();
      check("t5_err_sticky", err_orphan, 1);
      pos();
    end

    // asynchronous reset with a staged request and two pending
    set_req(2, 26'h4002, 1'b0, 1'b0);
    set_req(3, 26'h4003, 1'b0, 1'b0);
    neg();
    expect_grant("t6_g2", 2);
    pos();
    clr_req(2);
    neg();
    expect_grant("t6_g3", 3);
    pos();
    clr_req(3);
    filt_req_ready = 1'b0;
    neg();
    check("t6_staged", filt_req_valid, 1);
    pos();
    reset = 1'b1;
    sb.delete();
    #2;
    check("t6_async_frv", filt_req_valid, 0);
    check("t6_async_err", err_orphan, 0);
    neg();
    pos();
    reset = 1'b0;
    filt_req_ready = 1'b1;
    set_req(0, 26'h5000, 1'b1, 1'b1);
    set_req(2, 26'h4002, 1'b0, 1'b0);
    set_req(3, 26'h4003, 1'b0, 1'b0);
    neg();
    check("t6_frv_low", filt_req_valid, 0);
    expect_grant("t6_g0_first", 0);
    pos();
    req_valid = '0;
    neg();
    pos();
    check("sb_drained", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/broadcast_filter_sched.md
# broadcast_filter_sched

Scheduler in front of the broadcast hub's probe filter. It arbitrates filter lookups from the hub's trackers (MSHRs) round-robin and registers the winner into a one-entry output stage. It blocks any tracker that already has a lookup in flight, and any request whose address matches an in-flight lookup. Filter responses are routed back to the issuing tracker by the `mshr` tag.

## Interface
Parameters:
- `N_TRACKERS`, 4: number of requesting trackers; power of two, at least 2.
- `MSHR_W`, 2: log2(N_TRACKERS); tag width.
- `ADDR_W`, 26: block address width.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in N_TRACKERS: per-tracker lookup request.
- `req_ready` out N_TRACKERS: per-tracker grant; combinational.
- `req_address` in N_TRACKERS*ADDR_W: tracker i at bits [i*ADDR_W +: ADDR_W].
- `req_allocOH` in N_TRACKERS: per-tracker allocate flag.
- `req_needT` in N_TRACKERS: per-tracker needT flag.
- `filt_req_valid`, `filt_req_ready` out/in 1: handshake to the filter.
- `filt_req_mshr` out MSHR_W: granted tracker index.
- `filt_req_address` out ADDR_W.
- `filt_req_allocOH`, `filt_req_needT` out 1 each.
- `filt_resp_valid`, `filt_resp_ready` in/out 1: handshake from the filter.
- `filt_resp_mshr` in MSHR_W.
- `filt_resp_allocOH`, `filt_resp_needT` in 1 each.
- `resp_valid` out N_TRACKERS: one-hot response valid.
- `resp_ready` in N_TRACKERS.
- `resp_allocOH`, `resp_needT` out 1 each: broadcast to all trackers; qualified by `resp_valid`.
- `err_orphan` out 1: sticky; set by a response to a non-pending tracker.

## Operation
State held:
- `pending[N]` bits.
- `pend_addr[N]` registers.
- Round-robin pointer `last` (MSHR_W).
- Output stage: `ovalid` plus stored mshr/address/allocOH/needT.
- `err_orphan`.

Arbitration:
- Eligible(i) = `req_valid[i]` & ~`pending[i]` & ~conflict(i).
- conflict(i) = OR over j of (`pending[j]` & `pend_addr[j]` == `req_address[i]`), full ADDR_W compare on registered state only.
- `slot_free` = ~`ovalid` | `filt_req_ready`.
- If `slot_free`, grant the first eligible index scanning last+1, last+2, … modulo N. Exactly one `req_ready` bit is high; none when nothing is eligible or the slot is not free.

On grant g:
- Output stage loads {g, `req_address[g]`, `req_allocOH[g]`, `req_needT[g]`} and sets `ovalid`.
- `pending[g]` <= 1, `pend_addr[g]` <= address, `last` <= g.

Output handshake:
- `filt_req_*` are driven from the output stage.
- On `filt_req_ready` with no new grant, `ovalid` <= 0.
- On ready with a grant in the same cycle, the stage reloads (back-to-back, full throughput).

Response path (combinational):
- `resp_valid[k]` = `filt_resp_valid` & (`filt_resp_mshr` == k).
- `filt_resp_ready` = `resp_ready[filt_resp_mshr]`.
- On handshake, `pending[mshr]` <= 0.
- On handshake with `pending[mshr]` == 0, `err_orphan` <= 1 (sticky until reset). The response is still passed through.

## Timing
- Reset values: `filt_req_valid`=0, all `pending`=0, `last`=N-1 (tracker 0 has first priority), `err_orphan`=0.
- With `filt_resp_valid`=0: `resp_valid`=0 and `filt_resp_ready`=0.
- Stored output fields reset to 0.
- Latency: `req_valid`&`req_ready` in cycle t gives `filt_req_valid`=1 in cycle t+1.
- Throughput: one grant per cycle while `filt_req_ready`=1.
- Output stage holds stable while `filt_req_valid`=1 and `filt_req_ready`=0; no grants occur in that state.
- Response clearing `pending[k]` in cycle t: tracker k (and any address conflict it was causing) becomes eligible in t+1, never in t.
- Two trackers with equal addresses eligible in the same cycle: only the RR winner is granted. The other is blocked from t+1 by conflict.
- A response for tracker k may arrive while k's request still sits in the output stage: it is accepted and clears `pending`, and the stage is unaffected.
- `reset` asserted mid-operation: all state clears immediately (asynchronous). An in-flight filter request is dropped and `filt_req_valid` falls without a handshake.

## Test plan
- Reset then idle: all outputs at reset values. Tracker 2 requests address 0x12345, needT=1 in cycle 1 → `req_ready[2]`=1 in cycle 1; cycle 2 `filt_req_valid`=1, mshr=2, address=0x12345, needT=1.
- All four trackers request distinct addresses, `filt_req_ready` held 1 → grants in order 0,1,2,3 on consecutive cycles. Responses cleared in any order → all `pending` back to 0.
- Trackers 1 and 3 both request 0x0ABC → only 1 granted. Tracker 3's `req_ready` stays 0 until the cycle after tracker 1's response handshake, then it is granted.
- `filt_req_ready`=0 for 5 cycles with tracker 0 staged → `filt_req_*` stable, no `req_ready` asserted. Ready rises → same-cycle reload from tracker 1 if it is requesting.
- Response mshr=1 with `resp_ready[1]`=0 for 3 cycles → `resp_valid`=4'b0010 held and `filt_resp_ready`=0. Then ready=1 → handshake and `pending[1]` cleared. Response for non-pending mshr=3 → `err_orphan`=1, sticky.
- Assert `reset` for one cycle while `filt_req_valid`=1 and two trackers are pending → next cycle `filt_req_valid`=0, `pending`=0, and tracker 0 wins first.
